// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and types for the fetch stage
package if_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // Legal instruction-text window, inclusive on both ends.
    localparam logic [31:0] TEXT_LO = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI = 32'h0000_6FFC;

    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, bubble and hold
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   load                  capture instr_in/pc_in/pc_plus4_in, mark valid
//   bubble                replace instruction with NOP and mark invalid; PCs held
//   instr_in, pc_in, pc_plus4_in   values loaded on load
//   exc_in, d_exc         address-error flag (only with IF_ADEL_CHECK_EN)
//   d_instr, d_pc, d_pc_plus4, d_valid   register contents
// Neither load nor bubble holds every field.
module if_id_reg import if_pkg::*; #(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc_plus4_in,
`ifdef IF_ADEL_CHECK_EN
    input  logic        exc_in,
    output logic        d_exc,
`endif
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc_plus4,
    output logic        d_valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            d_instr    <= NOP_INSTR;
            d_pc       <= '0;
            d_pc_plus4 <= '0;
            d_valid    <= 1'b0;
`ifdef IF_ADEL_CHECK_EN
            d_exc      <= 1'b0;
`endif
        end else if (load) begin
            d_instr    <= instr_in;
            d_pc       <= pc_in;
            d_pc_plus4 <= pc_plus4_in;
            d_valid    <= 1'b1;
`ifdef IF_ADEL_CHECK_EN
            d_exc      <= exc_in;
`endif
        end else if (bubble) begin
            d_instr    <= NOP_INSTR;
            d_valid    <= 1'b0;
`ifdef IF_ADEL_CHECK_EN
            d_exc      <= 1'b0;
`endif
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with PC, skid buffer, redirect and IF/ID register
//
// Optional feature macro: IF_ADEL_CHECK_EN (adds D_ExcAdEL, address-error check on PC).
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   NPC_in                next PC from npc, meaningful while D_Valid=1
//   stall                 hazard stall, freezes PC and IF/ID
//   imem_req, imem_addr   fetch request and word address
//   imem_rdata, imem_ready   returned instruction and completion strobe
//   F_Busy                fetch is waiting on memory
//   D_Instr, D_PC, D_PCplus4, D_Valid   IF/ID contents toward decode
//   D_ExcAdEL             fetch address error (IF_ADEL_CHECK_EN only)
module if_stage import if_pkg::*; #(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] NPC_in,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        F_Busy,
`ifdef IF_ADEL_CHECK_EN
    output logic        D_ExcAdEL,
`endif
    output logic [31:0] D_Instr,
    output logic [31:0] D_PC,
    output logic [31:0] D_PCplus4,
    output logic        D_Valid
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  buf_instr;
    logic         buf_valid;
    logic [31:0]  redir_pc;
    logic         redir_valid;

    logic         adel;
    logic         fetched;
    logic         advance;
    logic         bubble;
    logic         skid_capture;
    logic [31:0]  pc_plus4;
    logic [31:0]  pc_next;
    logic [31:0]  instr_sel;

    assign pc_plus4 = pc + 32'd4;

`ifdef IF_ADEL_CHECK_EN
    assign adel      = (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);
    assign imem_addr = pc;
`else
    assign adel      = 1'b0;
    assign imem_addr = {pc[31:2], 2'b00};
`endif

    // Both FSM states keep the request up; only a full skid buffer or a
    // faulting PC suppresses it.
    assign imem_req = !buf_valid && !adel;

    // A faulting PC counts as fetched so the NOP/exception flows into D.
    assign fetched      = buf_valid || imem_ready || adel;
    assign advance      = fetched && !stall;
    assign bubble       = !fetched && !stall;
    assign skid_capture = stall && imem_ready && !buf_valid && !adel;

    assign F_Busy = ((state == WAIT) || imem_req) && !imem_ready && !buf_valid;

    assign instr_sel = adel      ? NOP_INSTR :
                       buf_valid ? buf_instr : imem_rdata;

    // A pending redirect wins: it is the branch target that left D while
    // the delay slot was still waiting on memory.
    assign pc_next = redir_valid ? redir_pc :
                     D_Valid     ? NPC_in   : pc_plus4;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= PC_RESET;
            state       <= REQ;
            buf_instr   <= '0;
            buf_valid   <= 1'b0;
            redir_pc    <= '0;
            redir_valid <= 1'b0;
        end else begin
            if (advance) begin
                pc          <= pc_next;
                buf_valid   <= 1'b0;
                redir_valid <= 1'b0;
            end else if (bubble) begin
                // D is about to become a bubble; keep its NPC so it is not lost.
                if (D_Valid && !redir_valid) begin
                    redir_pc    <= NPC_in;
                    redir_valid <= 1'b1;
                end
            end else if (skid_capture) begin
                buf_instr <= imem_rdata;
                buf_valid <= 1'b1;
            end

            case (state)
                REQ:     if (!imem_ready && !buf_valid && !adel) state <= WAIT;
                WAIT:    if (imem_ready) state <= REQ;
                default: state <= REQ;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk         (clk),
        .reset       (reset),
        .load        (advance),
        .bubble      (bubble),
        .instr_in    (instr_sel),
        .pc_in       (pc),
        .pc_plus4_in (pc_plus4),
`ifdef IF_ADEL_CHECK_EN
        .exc_in      (adel),
        .d_exc       (D_ExcAdEL),
`endif
        .d_instr     (D_Instr),
        .d_pc        (D_PC),
        .d_pc_plus4  (D_PCplus4),
        .d_valid     (D_Valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;
    import if_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, imem_ready;
    logic [31:0] NPC_in, imem_rdata;
    logic        imem_req, F_Busy, D_Valid;
    logic [31:0] imem_addr, D_Instr, D_PC, D_PCplus4;
`ifdef IF_ADEL_CHECK_EN
    logic        D_ExcAdEL;
`endif

    int total = 0;
    int bad   = 0;

    if_stage dut (
        .clk        (clk),
        .reset      (reset),
        .NPC_in     (NPC_in),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .F_Busy     (F_Busy),
`ifdef IF_ADEL_CHECK_EN
        .D_ExcAdEL  (D_ExcAdEL),
`endif
        .D_Instr    (D_Instr),
        .D_PC       (D_PC),
        .D_PCplus4  (D_PCplus4),
        .D_Valid    (D_Valid)
    );

    // Reference model: architectural view of fetch (PC, pending instruction,
    // pending branch target) and the contents of decode.
    logic [31:0] m_pc, m_buf, m_rpc, m_di, m_dpc, m_dpc4;
    logic        m_bufv, m_rv, m_dv;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic pc_bad(input logic [31:0] p);
`ifdef IF_ADEL_CHECK_EN
        return (p % 4 != 0) || (p < 32'h3000) || (p > 32'h6FFC);
`else
        return (p != p);
`endif
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] p);
`ifdef IF_ADEL_CHECK_EN
        return p;
`else
        return p - (p % 4);
`endif
    endfunction

    task automatic model_edge();
        logic        fault;
        logic [31:0] nxt;
        fault = pc_bad(m_pc);
        if (reset) begin
            m_pc = 32'h3000; m_bufv = 0; m_rv = 0;
            m_di = 0; m_dpc = 0; m_dpc4 = 0; m_dv = 0;
        end else if (!stall && (m_bufv || imem_ready || fault)) begin
            if (m_rv)      nxt = m_rpc;
            else if (m_dv) nxt = NPC_in;
            else           nxt = m_pc + 4;
            m_di   = fault ? 32'h0 : (m_bufv ? m_buf : imem_rdata);
            m_dpc  = m_pc;
            m_dpc4 = m_pc + 4;
            m_dv   = 1; m_bufv = 0; m_rv = 0;
            m_pc   = nxt;
        end else if (!stall) begin
            if (m_dv && !m_rv) begin m_rv = 1; m_rpc = NPC_in; end
            m_di = 0; m_dv = 0;
        end else if (imem_ready && !m_bufv && !fault) begin
            m_bufv = 1; m_buf = imem_rdata;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; stall = 0; imem_ready = 0; NPC_in = 0; imem_rdata = 0;
        cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; imem_ready = 0; NPC_in = 32'h1234_5678; imem_rdata = 32'hFFFF_FFFF;
        cycle(); cycle();
        reset = 0;
        @(negedge clk);
        total++; if (D_Valid !== 1'b0) begin bad++; $display("FAIL rst_dvalid got=%h want=0", D_Valid); end
        total++; if (D_Instr !== 32'h0) begin bad++; $display("FAIL rst_dinstr got=%h want=0", D_Instr); end
        total++; if (D_PC !== 32'h0) begin bad++; $display("FAIL rst_dpc got=%h want=0", D_PC); end
        total++; if (D_PCplus4 !== 32'h0) begin bad++; $display("FAIL rst_dpc4 got=%h want=0", D_PCplus4); end
        total++; if (imem_addr !== 32'h3000) begin bad++; $display("FAIL rst_addr got=%h want=3000", imem_addr); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_req got=%h want=1", imem_req); end
        total++; if (F_Busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%h want=1", F_Busy); end
        cycle();
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        do_reset();
        imem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            a = 32'h3000 + 32'(4 * i);
            imem_rdata = mem_word(a);
            NPC_in = m_dpc4 + 4;
            @(negedge clk);
            total++; if (imem_addr !== a) begin bad++; $display("FAIL seq_addr%0d got=%h want=%h", i, imem_addr, a); end
            if (i > 0) begin
                total++; if (D_PC !== a - 4) begin bad++; $display("FAIL seq_dpc%0d got=%h want=%h", i, D_PC, a - 4); end
                total++; if (D_Instr !== mem_word(a - 4)) begin bad++; $display("FAIL seq_dinstr%0d got=%h want=%h", i, D_Instr, mem_word(a - 4)); end
            end
            cycle();
        end
    endtask

    task automatic test_branch(input int waits);
        do_reset();
        imem_ready = 1;
        imem_rdata = mem_word(32'h3000); cycle();
        NPC_in = 32'h3008; imem_rdata = mem_word(32'h3004); cycle();
        // D now holds the branch at 0x3004; the delay slot 0x3008 is being fetched.
        NPC_in = 32'h3040;
        imem_rdata = mem_word(32'h3008);
        for (int w = 0; w < waits; w++) begin
            imem_ready = 0;
            @(negedge clk);
            total++; if (F_Busy !== 1'b1) begin bad++; $display("FAIL br_busy w%0d got=%h want=1", w, F_Busy); end
            total++; if (imem_addr !== 32'h3008) begin bad++; $display("FAIL br_waddr w%0d got=%h want=3008", w, imem_addr); end
            if (w > 0) begin
                total++; if (D_Valid !== 1'b0) begin bad++; $display("FAIL br_bubble w%0d got=%h want=0", w, D_Valid); end
            end
            cycle();
            NPC_in = 32'hDEAD_BEE0;
        end
        imem_ready = 1;
        @(negedge clk);
        total++; if (F_Busy !== 1'b0) begin bad++; $display("FAIL br_rdybusy got=%h want=0", F_Busy); end
        cycle();
        NPC_in = 32'h3048;
        @(negedge clk);
        total++; if (D_PC !== 32'h3008) begin bad++; $display("FAIL br_slot_pc w=%0d got=%h want=3008", waits, D_PC); end
        total++; if (D_Valid !== 1'b1) begin bad++; $display("FAIL br_slot_v w=%0d got=%h want=1", waits, D_Valid); end
        total++; if (D_Instr !== mem_word(32'h3008)) begin bad++; $display("FAIL br_slot_i w=%0d got=%h want=%h", waits, D_Instr, mem_word(32'h3008)); end
        total++; if (imem_addr !== 32'h3040) begin bad++; $display("FAIL br_target w=%0d got=%h want=3040", waits, imem_addr); end
        cycle();
    endtask

    task automatic test_skid();
        do_reset();
        imem_ready = 1; imem_rdata = mem_word(32'h3000); cycle();
        stall = 1; imem_rdata = 32'h2408_0005;
        @(negedge clk);
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL skid_req1 got=%h want=1", imem_req); end
        total++; if (imem_addr !== 32'h3004) begin bad++; $display("FAIL skid_addr got=%h want=3004", imem_addr); end
        cycle();
        @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL skid_req2 got=%h want=0", imem_req); end
        total++; if (D_PC !== 32'h3000) begin bad++; $display("FAIL skid_hold got=%h want=3000", D_PC); end
        total++; if (D_Instr !== mem_word(32'h3000)) begin bad++; $display("FAIL skid_holdi got=%h want=%h", D_Instr, mem_word(32'h3000)); end
        cycle();
        stall = 0; imem_ready = 0; NPC_in = 32'h3008;
        @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL skid_req3 got=%h want=0", imem_req); end
        total++; if (F_Busy !== 1'b0) begin bad++; $display("FAIL skid_busy got=%h want=0", F_Busy); end
        cycle();
        @(negedge clk);
        total++; if (D_Instr !== 32'h2408_0005) begin bad++; $display("FAIL skid_drain got=%h want=24080005", D_Instr); end
        total++; if (D_PC !== 32'h3004) begin bad++; $display("FAIL skid_dpc got=%h want=3004", D_PC); end
        total++; if (imem_addr !== 32'h3008) begin bad++; $display("FAIL skid_next got=%h want=3008", imem_addr); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL skid_req4 got=%h want=1", imem_req); end
        cycle();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        imem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            imem_rdata = mem_word(m_pc); NPC_in = m_dpc4 + 4; cycle();
        end
        imem_ready = 0; NPC_in = 32'h3050;
        @(negedge clk);
        total++; if (imem_addr !== 32'h3010) begin bad++; $display("FAIL rw_addr got=%h want=3010", imem_addr); end
        cycle(); cycle();
        reset = 1; cycle(); reset = 0;
        @(negedge clk);
        total++; if (imem_addr !== 32'h3000) begin bad++; $display("FAIL rw_pc got=%h want=3000", imem_addr); end
        total++; if (D_Valid !== 1'b0) begin bad++; $display("FAIL rw_dv got=%h want=0", D_Valid); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rw_req got=%h want=1", imem_req); end
        imem_ready = 1; imem_rdata = mem_word(32'h3000); NPC_in = 32'hDEAD_0000;
        cycle();
        @(negedge clk);
        total++; if (imem_addr !== 32'h3004) begin bad++; $display("FAIL rw_noredir got=%h want=3004", imem_addr); end
        total++; if (D_Instr !== mem_word(32'h3000)) begin bad++; $display("FAIL rw_instr got=%h want=%h", D_Instr, mem_word(32'h3000)); end
        cycle();
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ready = 1; imem_rdata = mem_word(32'h3000); cycle();
        NPC_in = 32'hFFFF_FFFC; cycle();
        NPC_in = 32'h0000_0000; cycle();
        @(negedge clk);
        total++; if (D_PC !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%h want=fffffffc", D_PC); end
        total++; if (D_PCplus4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h want=0", D_PCplus4); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h want=0", imem_addr); end
        cycle();
    endtask

`ifdef IF_ADEL_CHECK_EN
    task automatic test_adel();
        do_reset();
        imem_ready = 1; imem_rdata = mem_word(32'h3000); cycle();
        NPC_in = 32'h3002; imem_rdata = mem_word(32'h3004); cycle();
        imem_ready = 0; imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL adel_req got=%h want=0", imem_req); end
        cycle();
        @(negedge clk);
        total++; if (D_ExcAdEL !== 1'b1) begin bad++; $display("FAIL adel_exc got=%h want=1", D_ExcAdEL); end
        total++; if (D_Instr !== 32'h0) begin bad++; $display("FAIL adel_instr got=%h want=0", D_Instr); end
        total++; if (D_Valid !== 1'b1) begin bad++; $display("FAIL adel_valid got=%h want=1", D_Valid); end
        total++; if (D_PC !== 32'h3002) begin bad++; $display("FAIL adel_pc got=%h want=3002", D_PC); end
        cycle();
    endtask
`endif

    task automatic test_random();
        logic        e_req, e_busy;
        logic [31:0] e_addr;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom % 100) == 0;
            stall = ($urandom % 4) == 0;
            imem_ready = (!m_bufv && !pc_bad(m_pc)) ? (($urandom % 5) < 3) : 1'b0;
            imem_rdata = $urandom;
            if (($urandom % 5) == 0) NPC_in = 32'h3000 + 32'(4 * ($urandom % 32'h1000));
            else                     NPC_in = m_dpc4 + 4;
            e_req  = !m_bufv && !pc_bad(m_pc);
            e_busy = !m_bufv && !imem_ready && !pc_bad(m_pc);
            e_addr = exp_addr(m_pc);
            @(negedge clk);
            total++; if (imem_req !== e_req) begin bad++; $display("FAIL rnd_req c%0d got=%h want=%h", i, imem_req, e_req); end
            total++; if (imem_addr !== e_addr) begin bad++; $display("FAIL rnd_addr c%0d got=%h want=%h", i, imem_addr, e_addr); end
            total++; if (F_Busy !== e_busy) begin bad++; $display("FAIL rnd_busy c%0d got=%h want=%h", i, F_Busy, e_busy); end
            total++; if (D_Valid !== m_dv) begin bad++; $display("FAIL rnd_dv c%0d got=%h want=%h", i, D_Valid, m_dv); end
            total++; if (D_Instr !== m_di) begin bad++; $display("FAIL rnd_di c%0d got=%h want=%h", i, D_Instr, m_di); end
            total++; if (D_PC !== m_dpc) begin bad++; $display("FAIL rnd_dpc c%0d got=%h want=%h", i, D_PC, m_dpc); end
            total++; if (D_PCplus4 !== m_dpc4) begin bad++; $display("FAIL rnd_dpc4 c%0d got=%h want=%h", i, D_PCplus4, m_dpc4); end
            cycle();
        end
        reset = 0; stall = 0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch(0);
        test_branch(3);
        test_skid();
        test_reset_mid_wait();
        test_wrap();
`ifdef IF_ADEL_CHECK_EN
        test_adel();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
